// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave: controller state encoding and byte geometry.
package i2c_pkg;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, plus rise/fall detection
// on the synchronized value. Resets to the idle-high bus level.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [1:0] synchronizer stages, [2] previous synchronized value
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], d_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q_o    = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a byte buffer shared between the bus and a host port.
// Bus writes fill the buffer from a pointer; bus reads stream it back.
module i2c_slave import i2c_pkg::*; #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [7:0]                   mem_wdata,
  output logic [7:0]                   mem_rdata,
  output logic                         rx_valid,
  output logic [7:0]                   rx_data,
  output logic                         busy
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam logic [3:0]  LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [3:0]  ALL_BITS = 4'(I2C_BITS_PER_BYTE);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (scl_i),
    .q_o    (scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sda_i),
    .q_o    (sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic bus_start, bus_stop;
  assign bus_start = sda_fall & scl_s;
  assign bus_stop  = sda_rise & scl_s;

  i2c_slave_state_t state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sda_q, sda_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          bus_we;
  logic [7:0]    bus_wdata;
  logic [7:0]    rd_byte;

  logic [7:0] mem_q [MEM_DEPTH];

  assign rd_byte   = mem_q[ptr_q];
  assign bus_wdata = {shift_q, sda_s};

  // In the ACK states bit_cnt acts as a phase flag: 0 = ACK not yet driven.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_d      = sda_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    bus_we     = 1'b0;
    if (bus_start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      ptr_d     = '0;
      sda_d     = 1'b1;
    end else if (bus_stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                rw_d    = sda_s;
                sda_d   = 1'b1;
                state_d = (shift_q == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
              end else begin
                bus_we     = 1'b1;
                rx_valid_d = 1'b1;
                rx_data_d  = bus_wdata;
                ptr_d      = ptr_q + AW'(1);
                state_d    = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_d     = 1'b0;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                tx_d    = rd_byte;
                sda_d   = rd_byte[7];
                state_d = RD_DATA;
              end else begin
                sda_d   = 1'b1;
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == ALL_BITS) begin
              sda_d     = 1'b1;
              ptr_d     = ptr_q + AW'(1);
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_d = tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d   = WAIT_STOP;
            else       bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            tx_d      = rd_byte;
            sda_d     = rd_byte[7];
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end
        end
        WAIT_STOP: sda_d = 1'b1;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_q      <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_q      <= sda_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Bus write is issued last so it takes precedence on a same-index collision.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
    if (bus_we) mem_q[ptr_q]    <= bus_wdata;
  end

  assign mem_rdata = mem_q[mem_addr];
  assign sda_o     = sda_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign busy      = !(state_q inside {IDLE, WAIT_STOP});

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: an open-drain bus master plus a scoreboard
// that pairs expected bytes/levels with what the slave presents.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned Q     = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o;
  logic       sda_line;
  logic       mem_we = 1'b0;
  logic [3:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic [7:0] mem_rdata;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;

  assign sda_line = sda_m & sda_o;

  i2c_slave #(.SLAVE_ADDR(7'h42), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_rx[$];
  int         tests = 0;
  int         fails = 0;
  int         sda_low_cnt = 0;

  // Scoreboard monitor: rx_valid pulses against exp_rx, observations against exp_q.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] o;
    logic [7:0] er;
    if (rst_n && rx_valid) begin
      tests++;
      if (exp_rx.size() == 0) begin
        fails++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no pulse", rx_data);
      end else begin
        er = exp_rx.pop_front();
        if (rx_data !== er) begin
          fails++;
          $display("FAIL rx_data: got %02h required %02h", rx_data, er);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL orphan_obs: got %02h with no expectation", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e.v) begin
          fails++;
          $display("FAIL %s: got %02h required %02h", e.name, o, e.v);
        end
      end
    end
    if (!sda_o) sda_low_cnt++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic expect8(input string name, input logic [7:0] e, input logic [7:0] o);
    exp_q.push_back('{name, e});
    obs_q.push_back(o);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(2*Q);
    sda_m = 1'b0; wclk(2*Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(Q);
    scl = 1'b1;   wclk(2*Q);
    sda_m = 1'b1; wclk(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;  wclk(Q);
    scl = 1'b1; wclk(2*Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(Q);
    b = sda_line; wclk(Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    expect8(name, {7'd0, exp_ack}, {7'd0, a});
  endtask

  task automatic rd_byte(input string name, input logic [7:0] e, input logic ack);
    logic [7:0] d;
    logic       b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
    expect8(name, e, d);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic chk_mem(input string name, input logic [3:0] a, input logic [7:0] e);
    @(negedge clk);
    mem_addr = a;
    #1 expect8(name, e, mem_rdata);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   low_snap;
    int   left;
    logic b;

    // reset values
    wclk(3);
    @(negedge clk);
    expect8("rst_sda_o", 8'h01, {7'd0, sda_o});
    expect8("rst_busy", 8'h00, {7'd0, busy});
    expect8("rst_rx_valid", 8'h00, {7'd0, rx_valid});
    expect8("rst_rx_data", 8'h00, rx_data);
    rst_n = 1'b1;
    wclk(4);

    // write A5, 3C
    bus_start();
    wr_byte("w1_addr_ack", 8'h84, 1'b0);
    @(negedge clk);
    expect8("w1_busy", 8'h01, {7'd0, busy});
    exp_rx.push_back(8'hA5);
    wr_byte("w1_d0_ack", 8'hA5, 1'b0);
    exp_rx.push_back(8'h3C);
    wr_byte("w1_d1_ack", 8'h3C, 1'b0);
    bus_stop();
    chk_mem("w1_mem0", 4'd0, 8'hA5);
    chk_mem("w1_mem1", 4'd1, 8'h3C);
    expect8("w1_rx_data", 8'h3C, rx_data);
    expect8("w1_idle_busy", 8'h00, {7'd0, busy});

    // read back two bytes
    bus_start();
    wr_byte("r1_addr_ack", 8'h85, 1'b0);
    rd_byte("r1_d0", 8'hA5, 1'b0);
    rd_byte("r1_d1", 8'h3C, 1'b1);
    bus_stop();
    @(negedge clk);
    expect8("r1_sda_after_stop", 8'h01, {7'd0, sda_o});

    // foreign address: no ACK, no write
    low_snap = sda_low_cnt;
    bus_start();
    wr_byte("x_addr_nack", 8'h42, 1'b1);
    wr_byte("x_data_nack", 8'h11, 1'b1);
    bus_stop();
    @(negedge clk);
    expect8("x_sda_never_low", 8'h00, (sda_low_cnt == low_snap) ? 8'h00 : 8'h01);
    expect8("x_busy", 8'h00, {7'd0, busy});
    chk_mem("x_mem0", 4'd0, 8'hA5);
    chk_mem("x_mem1", 4'd1, 8'h3C);

    // 17-byte write wraps the pointer
    bus_start();
    wr_byte("wrap_addr_ack", 8'h84, 1'b0);
    for (int i = 0; i < 17; i++) begin
      exp_rx.push_back(8'(i));
      wr_byte("wrap_data_ack", 8'(i), 1'b0);
    end
    bus_stop();
    chk_mem("wrap_mem0", 4'd0, 8'h10);
    chk_mem("wrap_mem1", 4'd1, 8'h01);
    chk_mem("wrap_mem15", 4'd15, 8'h0F);

    // host preload, read three with NACK on the last
    host_wr(4'd0, 8'h5A);
    host_wr(4'd1, 8'h6B);
    host_wr(4'd2, 8'h7C);
    bus_start();
    wr_byte("r3_addr_ack", 8'h85, 1'b0);
    rd_byte("r3_d0", 8'h5A, 1'b0);
    rd_byte("r3_d1", 8'h6B, 1'b0);
    rd_byte("r3_d2", 8'h7C, 1'b1);
    @(negedge clk);
    expect8("r3_wait_stop", 8'(WAIT_STOP), 8'(dut.state_q));
    expect8("r3_nack_busy", 8'h00, {7'd0, busy});
    bus_stop();
    @(negedge clk);
    expect8("r3_idle", 8'(IDLE), 8'(dut.state_q));

    // reset while the slave drives a read bit low
    host_wr(4'd0, 8'h00);
    bus_start();
    wr_byte("rr_addr_ack", 8'h85, 1'b0);
    for (int i = 0; i < 3; i++) get_bit(b);
    @(negedge clk);
    expect8("rr_driving_low", 8'h00, {7'd0, sda_o});
    rst_n = 1'b0;
    #1;
    expect8("rr_async_release", 8'h01, {7'd0, sda_o});
    expect8("rr_busy", 8'h00, {7'd0, busy});
    wclk(3);
    @(negedge clk);
    rst_n = 1'b1;
    wclk(2);
    bus_stop();
    bus_start();
    wr_byte("rr_w_addr_ack", 8'h84, 1'b0);
    exp_rx.push_back(8'h99);
    wr_byte("rr_w_data_ack", 8'h99, 1'b0);
    bus_stop();
    chk_mem("rr_mem0", 4'd0, 8'h99);

    for (int i = 0; i < 100 && obs_q.size() > 0; i++) @(posedge clk);
    wclk(2);
    left = exp_q.size();
    expect8("rx_leftover", 8'h00, 8'(exp_rx.size()));
    expect8("bus_leftover", 8'h00, 8'(left));
    wclk(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h42, 7-bit bus address the block responds to.
REQ-002 Parameter MEM_DEPTH, default 16, number of byte entries in the internal buffer (power of 2).
REQ-003 clk  input  1  system clock; only clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 scl_i  input  1  bus SCL level, asynchronous to clk.
REQ-006 sda_i  input  1  bus SDA level, asynchronous to clk.
REQ-007 sda_o  output  1  open-drain SDA drive: 0 pulls low, 1 releases.
REQ-008 mem_we  input  1  host write strobe into buffer.
REQ-009 mem_addr  input  log2(MEM_DEPTH)  host buffer index.
REQ-010 mem_wdata  input  8  host write data.
REQ-011 mem_rdata  output  8  buffer[mem_addr], combinational.
REQ-012 rx_valid  output  1  one-clk pulse per bus-written byte.
REQ-013 rx_data  output  8  last bus-written byte, held until next.
REQ-014 busy  output  1  high from addressed START to STOP/mismatch/NACK end.

Function
REQ-015 scl_i and sda_i each pass a 2-flop synchronizer, then edge detection; all bus decisions use synchronized values.
REQ-016 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-017 Bus data sampled on synced SCL rising edge; sda_o changes only on synced SCL falling edge (1 clk after detection).
REQ-018 Supported bus timing: every SCL high/low phase and START/STOP setup ≥ 6 clk periods.
REQ-019 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-020 IDLE -> ADDR on START; byte pointer cleared to 0; bit counter cleared.
REQ-021 ADDR shifts 8 bits MSB first (7 address + R/Wn); on 8th bit, match -> ADDR_ACK, mismatch -> WAIT_STOP with sda_o=1.
REQ-022 ADDR_ACK: sda_o=0 for one SCL high phase, released on following SCL fall; then WR_DATA (R/Wn=0) or RD_DATA (R/Wn=1).
REQ-023 WR_DATA: shift 8 bits; on 8th sample write buffer[ptr], rx_data<=byte, rx_valid pulse, ptr++ mod MEM_DEPTH; -> WR_ACK (sda_o=0 one bit), -> WR_DATA.
REQ-024 RD_DATA: drive buffer[ptr] MSB first, bit n presented on SCL fall preceding its sample; after 8th bit release sda_o, ptr++ mod MEM_DEPTH, -> RD_ACK.
REQ-025 RD_ACK: sample master bit; 0 -> RD_DATA (next byte), 1 (NACK) -> WAIT_STOP.
REQ-026 WAIT_STOP: sda_o=1, ignores bits until STOP or START.
REQ-027 STOP in any state -> IDLE, sda_o=1, busy=0, partial byte discarded.
REQ-028 START in any non-IDLE state (repeated START) -> ADDR, ptr cleared.
REQ-029 Pointer overflow wraps to 0; writes beyond MEM_DEPTH overwrite from index 0.
REQ-030 Host mem_we and bus write same cycle same index: bus write wins; different index: both occur.
REQ-031 Host writes allowed while busy; a read byte already loaded for shifting is unaffected.

Reset
REQ-032 On rst_n low: state=IDLE, sda_o=1, busy=0, rx_valid=0, rx_data=0, ptr=0, bit counter=0, synchronizers=1.
REQ-033 Buffer contents not reset.
REQ-034 Reset mid-transaction releases SDA immediately (asynchronously); block then waits for a new START.

Structure
REQ-035 Shared package i2c_pkg holds state enum i2c_slave_state_t and I2C_BITS_PER_BYTE=8.
REQ-036 One sub-module i2c_sync_edge (2-flop sync, rise/fall outputs), instantiated for SCL and SDA.

Verification
REQ-037 Write 0xA5,0x3C to 0x42 -> ACK low on 3 ack bits, buffer[0]=A5, buffer[1]=3C, two rx_valid pulses, rx_data=3C.
REQ-038 Then read 2 bytes from 0x42, master ACK then STOP -> master receives A5,3C; sda_o=1 after STOP.
REQ-039 Write 0x11 to 0x21 -> sda_o stays 1 whole transaction, buffer unchanged, no rx_valid, busy=0.
REQ-040 Write 17 bytes 0x00..0x10 -> buffer[0]=0x10, buffer[1]=0x01, 17 rx_valid pulses.
REQ-041 Host preloads buffer[0..2]=0x5A,0x6B,0x7C; read 3, NACK on third -> bytes received in order, state WAIT_STOP then IDLE on STOP.
REQ-042 rst_n pulsed low during RD_DATA bit 3 -> sda_o=1 within reset, busy=0; next write of 0x99 to 0x42 stores buffer[0]=0x99.
